// File: rtl/fp_align_add.sv
// fp_align_add: aligns two IEEE-754 single operands by iterative right shift and adds/subtracts their mantissas.
module fp_align_add #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] sum,
  output logic [7:0]  exp,
  output logic        sign
);
  typedef enum logic [1:0] {IDLE, ALIGN, ADD, HOLD} state_t;
  localparam logic [7:0] STEP = 8'(SHIFT_STEP);
  state_t      state;
  logic [23:0] l_m, s_m, ma, mb;
  logic [22:0] fa, fb;
  logic [7:0]  l_e, rem, ea, eb, diff, step;
  logic        l_s, s_s, a_big;
  logic [24:0] add_res;
  // A zero exponent field means a zero operand, so its fraction is ignored too.
  always_comb begin
    ea      = a[30:23];
    eb      = b[30:23];
    fa      = ea == 8'd0 ? 23'd0 : a[22:0];
    fb      = eb == 8'd0 ? 23'd0 : b[22:0];
    ma      = ea == 8'd0 ? 24'd0 : {1'b1, fa};
    mb      = eb == 8'd0 ? 24'd0 : {1'b1, fb};
    a_big   = {ea, fa} >= {eb, fb};
    diff    = a_big ? ea - eb : eb - ea;
    step    = rem < STEP ? rem : STEP;
    add_res = l_s == s_s ? {1'b0, l_m} + {1'b0, s_m} : {1'b0, l_m} - {1'b0, s_m};
    in_ready = state == IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      l_m       <= '0;
      s_m       <= '0;
      l_e       <= '0;
      l_s       <= 1'b0;
      s_s       <= 1'b0;
      rem       <= '0;
      sum       <= '0;
      exp       <= '0;
      sign      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          l_m   <= a_big ? ma : mb;
          s_m   <= diff >= 8'd25 ? 24'd0 : (a_big ? mb : ma);
          l_e   <= a_big ? ea : eb;
          l_s   <= a_big ? a[31] : b[31];
          s_s   <= a_big ? b[31] : a[31];
          rem   <= diff >= 8'd25 ? 8'd0 : diff;
          state <= (diff != 8'd0 && diff < 8'd25) ? ALIGN : ADD;
        end
        ALIGN: begin
          s_m <= s_m >> step;
          rem <= rem - step;
          if (rem == step) state <= ADD;
        end
        ADD: begin
          sum       <= add_res;
          exp       <= l_e;
          sign      <= (l_s != s_s && add_res == 25'd0) ? 1'b0 : l_s;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add: scoreboard bench running SHIFT_STEP=1 and SHIFT_STEP=2 instances in lockstep.
module tb_fp_align_add;
  logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0;
  logic        ir1, ov1, sg1, ir2, ov2, sg2;
  logic [24:0] sum1, sum2;
  logic [7:0]  e1, e2;
  int          checks = 0, errors = 0, cyc = 0;
  logic        pv1 = 0, pv2 = 0;
  typedef struct {logic [24:0] s; logic [7:0] e; logic sg; int lat; int acc;} exp_t;
  exp_t q1[$], q2[$];

  fp_align_add #(.SHIFT_STEP(1)) dut1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .exp(e1), .sign(sg1));
  fp_align_add #(.SHIFT_STEP(2)) dut2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
    .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready), .sum(sum2), .exp(e2), .sign(sg2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic got(input int id, input logic [24:0] s, input logic [7:0] e, input logic sg);
    exp_t x;
    int n;
    n = id == 1 ? q1.size() : q2.size();
    checks++;
    assert (n != 0) else begin
      errors++;
      $error("FAIL unexpected_out%0d: observed out_valid 1 expected 0", id);
    end
    if (n != 0) begin
      if (id == 1) x = q1.pop_front(); else x = q2.pop_front();
      chk($sformatf("sum%0d", id), 32'(s), 32'(x.s));
      chk($sformatf("exp%0d", id), 32'(e), 32'(x.e));
      chk($sformatf("sign%0d", id), 32'(sg), 32'(x.sg));
      chk($sformatf("latency%0d", id), 32'(cyc - x.acc), 32'(x.lat));
    end
  endtask

  always @(negedge clk) begin
    if (ov1 && !pv1) got(1, sum1, e1, sg1);
    pv1 = ov1;
  end
  always @(negedge clk) begin
    if (ov2 && !pv2) got(2, sum2, e2, sg2);
    pv2 = ov2;
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [24:0] s,
                       input logic [7:0] e, input logic sg, input int lat1, input int lat2);
    @(negedge clk);
    a = ta; b = tb; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    q1.push_back('{s, e, sg, lat1, cyc});
    q2.push_back('{s, e, sg, lat2, cyc});
    chk("in_ready1_busy", 32'(ir1), 0);
    chk("in_ready2_busy", 32'(ir2), 0);
  endtask

  task automatic finish_txn(input int hold);
    int n = 0;
    logic [33:0] snap;
    while (!(ov1 && ov2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bound", 32'(n < 100), 1);
    snap = {sum1, e1, sg1};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1; a = $urandom; b = $urandom;
      @(negedge clk);
      in_valid = 0;
      chk("hold_stable", 32'({sum1, e1, sg1} == snap), 1);
      chk("hold_in_ready", 32'({ir1, ir2, ov1, ov2}), 32'b0011);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("idle_after_hold", 32'({ir1, ir2, ov1, ov2}), 32'b1100);
  endtask

  initial begin
    #1;
    chk("reset_outs", 32'({ov1, sum1, e1, sg1}), 0);
    chk("reset_in_ready", 32'({ir1, ir2}), 32'b11);
    @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_ready_no_effect", 32'({ir1, ov1}), 32'b10);
    reset = 0;
    issue(32'h3F800000, 32'h3F800000, 25'h1000000, 8'h7F, 0, 1, 1); finish_txn(0);
    issue(32'h3F800000, 32'h3F000000, 25'h0C00000, 8'h7F, 0, 2, 2); finish_txn(0);
    issue(32'h3F000000, 32'hC0000000, 25'h0600000, 8'h80, 1, 3, 2); finish_txn(0);
    issue(32'h3F800000, 32'hBF800000, 25'h0000000, 8'h7F, 0, 1, 1); finish_txn(0);
    issue(32'hBF800000, 32'h3F800000, 25'h0000000, 8'h7F, 0, 1, 1); finish_txn(0);
    issue(32'h4E800000, 32'h3F800000, 25'h0800000, 8'h9D, 0, 1, 1); finish_txn(0);
    issue(32'h4B800000, 32'h3F800000, 25'h0800000, 8'h97, 0, 25, 13); finish_txn(0);
    issue(32'h4C000000, 32'hBF800000, 25'h0800000, 8'h98, 0, 1, 1); finish_txn(0);
    issue(32'h40000000, 32'h3F800001, 25'h0C00000, 8'h80, 0, 2, 2); finish_txn(0);
    issue(32'h40000000, 32'hBF800001, 25'h0400000, 8'h80, 0, 2, 2); finish_txn(0);
    issue(32'h00000000, 32'hBF800000, 25'h0800000, 8'h7F, 1, 1, 1); finish_txn(0);
    issue(32'hC0000000, 32'hC0000000, 25'h1000000, 8'h80, 1, 1, 1); finish_txn(0);
    issue(32'h40400000, 32'h3F800000, 25'h1000000, 8'h80, 0, 2, 2); finish_txn(5);
    issue(32'h3F800000, 32'h3F000000, 25'h0C00000, 8'h7F, 0, 2, 2);
    begin
      int n = 0;
      while (!(ov1 && ov2) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("wait_bound_leave", 32'(n < 100), 1);
    end
    @(negedge clk);
    out_ready = 1; in_valid = 1; a = 32'h3F800000; b = 32'h3F800000;
    @(posedge clk);
    #1;
    out_ready = 0; in_valid = 0;
    chk("no_accept_on_leave", 32'({ir1, ir2, ov1, ov2}), 32'b1100);
    repeat (4) @(negedge clk);
    chk("still_idle", 32'({ir1, ir2}), 32'b11);
    issue(32'h49800000, 32'h3F800000, 25'h0800000, 8'h93, 0, 21, 11);
    repeat (5) @(posedge clk);
    #2;
    reset = 1;
    #1;
    q1.delete(); q2.delete();
    chk("mid_reset_outs1", 32'({ov1, sum1, e1, sg1}), 0);
    chk("mid_reset_outs2", 32'({ov2, sum2, e2, sg2}), 0);
    chk("mid_reset_in_ready", 32'({ir1, ir2}), 32'b11);
    @(negedge clk);
    reset = 0;
    repeat (30) @(negedge clk);
    chk("post_reset_quiet", 32'({ir1, ir2, ov1, ov2}), 32'b1100);
    issue(32'h3F800000, 32'h3F800000, 25'h1000000, 8'h7F, 0, 1, 1); finish_txn(0);
    chk("queues_empty", 32'(q1.size() + q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
